// File: rtl/regfile_req_if.sv
// Requester-side bundle for regfile_access_arbiter.
// master: core/debug requester; slave: the arbiter.
interface regfile_req_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;

  modport master (
    output req, we, ra1, ra2, wa, wd,
    input  gnt, rvalid, rd1, rd2
  );

  modport slave (
    input  req, we, ra1, ra2, wa, wd,
    output gnt, rvalid, rd1, rd2
  );
endinterface

// File: rtl/regfile_access_arbiter.sv
// Clears the 2R/1W register file after reset, then round-robins
// A/B transactions onto it. Ports: clk/rst, init_done, a/b, rf_*.
module regfile_access_arbiter #(
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int RF_AW = 6
) (
  input  logic             clk,
  input  logic             rst,
  output logic             init_done,
  regfile_req_if.slave     a,
  regfile_req_if.slave     b,
  output logic [RF_AW-1:0] rf_r1_addr,
  output logic [RF_AW-1:0] rf_r2_addr,
  output logic [RF_AW-1:0] rf_r3_addr,
  output logic [DW-1:0]    rf_r3_din,
  output logic             rf_r3_wr,
  input  logic [DW-1:0]    rf_r1_dout,
  input  logic [DW-1:0]    rf_r2_dout
);

  localparam logic [1:0] S_RST  = 2'd0;
  localparam logic [1:0] S_INIT = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam logic [AW-1:0] CNT_LAST = '1;

  logic [1:0]       state;
  logic [AW-1:0]    cnt;
  logic             last_b;
  logic [RF_AW-1:0] r1_q;
  logic [RF_AW-1:0] r2_q;
  logic [RF_AW-1:0] r3_q;
  logic [DW-1:0]    din_q;

  logic          run;
  logic          any_gnt;
  logic          w_we;
  logic [AW-1:0] w_ra1;
  logic [AW-1:0] w_ra2;
  logic [AW-1:0] w_wa;
  logic [DW-1:0] w_wd;
  logic          wr_en;

  function automatic logic [RF_AW-1:0] zext(
    input logic [AW-1:0] x
  );
    return {{(RF_AW-AW){1'b0}}, x};
  endfunction

  assign run = (state == S_RUN);

  // last_b=1 means B won last, so A wins a tie.
  assign a.gnt = run & a.req
               & (~b.req | last_b);
  assign b.gnt = run & b.req
               & (~a.req | ~last_b);
  assign any_gnt = a.gnt | b.gnt;

  always_comb begin
    w_we  = a.we;
    w_ra1 = a.ra1;
    w_ra2 = a.ra2;
    w_wa  = a.wa;
    w_wd  = a.wd;
    if (b.gnt) begin
      w_we  = b.we;
      w_ra1 = b.ra1;
      w_ra2 = b.ra2;
      w_wa  = b.wa;
      w_wd  = b.wd;
    end
  end

  // Register 0 is hardwired to zero: drop writes to it.
  assign wr_en = any_gnt & w_we
               & (w_wa != '0);

  always_comb begin
    rf_r1_addr = r1_q;
    rf_r2_addr = r2_q;
    rf_r3_addr = r3_q;
    rf_r3_din  = din_q;
    rf_r3_wr   = 1'b0;
    unique case (1'b1)
      (state == S_INIT): begin
        rf_r3_wr   = 1'b1;
        rf_r3_addr = zext(cnt);
        rf_r3_din  = '0;
      end
      any_gnt: begin
        rf_r1_addr = zext(w_ra1);
        rf_r2_addr = zext(w_ra2);
        if (wr_en) begin
          rf_r3_wr   = 1'b1;
          rf_r3_addr = zext(w_wa);
          rf_r3_din  = w_wd;
        end
      end
      default: ;
    endcase
  end

  // The file registers its read data, so it lines up
  // with rvalid one cycle after the grant.
  assign a.rd1 = rf_r1_dout;
  assign a.rd2 = rf_r2_dout;
  assign b.rd1 = rf_r1_dout;
  assign b.rd2 = rf_r2_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RST;
      cnt       <= '0;
      last_b    <= 1'b1;
      init_done <= 1'b0;
      a.rvalid  <= 1'b0;
      b.rvalid  <= 1'b0;
      r1_q      <= '0;
      r2_q      <= '0;
      r3_q      <= '0;
      din_q     <= '0;
    end else begin
      a.rvalid <= a.gnt;
      b.rvalid <= b.gnt;
      r1_q     <= rf_r1_addr;
      r2_q     <= rf_r2_addr;
      r3_q     <= rf_r3_addr;
      din_q    <= rf_r3_din;
      if (any_gnt) begin
        last_b <= b.gnt;
      end
      unique case (state)
        S_RST: begin
          state <= S_INIT;
          cnt   <= '0;
        end
        S_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state     <= S_RUN;
            init_done <= 1'b1;
          end
        end
        S_RUN: ;
        default: state <= S_RST;
      endcase
    end
  end

endmodule

// File: doc/regfile_access_arbiter.md
Name: regfile_access_arbiter

Overview:
- Sits in front of the 32x32 two-read/one-write register file.
- Clears all 32 entries after reset, then shares the register file between two requesters: A (core datapath) and B (debug/loader port).
- Grants one transaction per cycle using round-robin arbitration.
- Each transaction reads two registers and optionally writes one; read data returns with the register file's 1-cycle registered latency.

Parameters:
- AW, 5, requester register-address width (NREG = 2**AW entries).
- DW, 32, data width.
- RF_AW, 6, register-file address port width; upper bits are driven 0.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- init_done  out  1  high once the clear sweep has finished.
- a_req  in  1  requester A transaction valid; held stable until a_gnt.
- a_we  in  1  A transaction includes a write.
- a_ra1, a_ra2  in  AW  A read addresses.
- a_wa  in  AW  A write address.
- a_wd  in  DW  A write data.
- a_gnt  out  1  A transaction accepted this cycle (combinational).
- a_rvalid  out  1  A read data valid (registered).
- a_rd1, a_rd2  out  DW  A read data.
- b_req, b_we, b_ra1, b_ra2, b_wa, b_wd, b_gnt, b_rvalid, b_rd1, b_rd2: identical set for requester B.
- rf_r1_addr, rf_r2_addr, rf_r3_addr  out  RF_AW  to register file.
- rf_r3_din  out  DW  to register file.
- rf_r3_wr  out  1  to register file.
- rf_r1_dout, rf_r2_dout  in  DW  from register file; these are registered inside the file and valid 1 cycle after the address is presented.

Behaviour:
- Register-file integration: the file's own active-low async reset is tied inactive. This block performs the clear instead, because that reset only clears the entry currently addressed.
- States:
  - RST: while rst=1. Forces INIT next with cnt=0; all gnt, rvalid and rf_r3_wr are 0; init_done=0; last_grant=B so that A wins the first tie.
  - INIT: rf_r3_wr=1, rf_r3_addr=cnt, rf_r3_din=0, cnt increments each cycle. After cnt=NREG-1 the state goes to RUN and init_done is set (registered, so it rises the cycle after the last clear write). No gnt is issued in INIT; requests are held off.
  - RUN: arbitrate every cycle.
- Arbitration:
  - Only A requesting: A is granted. Only B requesting: B is granted.
  - Both requesting: grant the requester not granted last time. last_grant updates only on a grant.
  - At most one gnt per cycle.
- Granted cycle T:
  - rf_r1_addr/rf_r2_addr are driven from the winner's ra1/ra2, zero-extended.
  - If the winner's we=1 and wa!=0: rf_r3_wr=1, rf_r3_addr=wa, rf_r3_din=wd.
  - A write to address 0 is suppressed, so register 0 is always 0.
  - Idle cycles: rf_r3_wr=0; addresses hold their last value.
- Read return:
  - winner_rvalid=1 in cycle T+1 only.
  - rd1/rd2 are wired directly from rf_r1_dout/rf_r2_dout to both requesters. They are meaningful only while the corresponding rvalid is high.
- Hazards:
  - A read and a write to the same address in one transaction returns the OLD value (read-before-write).
  - A read granted at T+1 to an address written at T returns the NEW value. No bypass logic is required.
  - Back-to-back grants give full throughput: 1 transaction per cycle.
- Reset mid-operation (rst high during INIT or RUN): takes effect at the next edge. Any pending rvalid is dropped, and the INIT sweep restarts from 0.
- Width rule: AW < RF_AW; bits [RF_AW-1:AW] of every rf address are driven 0.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 0 -> rf_r3_wr=1 for exactly 32 cycles with addr 0..31 and din 0; init_done rises on cycle 33; no gnt during the sweep.
- Single A transaction (after init): a_req, a_we=1, a_wa=5, a_wd=32'hDEADBEEF -> a_gnt same cycle. A following read with a_ra1=5 returns a_rd1=32'hDEADBEEF with a_rvalid one cycle after its gnt.
- Read-before-write: a_ra1=7 and a_wa=7 in the same transaction with wd=32'h11 (reg7 was 0) -> a_rd1=0. The next transaction reading 7 -> 32'h11.
- Round-robin contention: a_req and b_req held high for 4 cycles -> grants A,B,A,B; each a_rvalid/b_rvalid pulses exactly once, one cycle after its gnt.
- Zero-register protection: b_we=1, b_wa=0, b_wd=32'hFFFFFFFF -> rf_r3_wr=0. Reading reg 0 -> 0.
- Reset mid-RUN: assert rst on the cycle A is granted -> a_rvalid stays 0 the next cycle; the INIT sweep restarts from address 0; previously written reg5 reads 0 afterwards.
